// File: rtl/mci_pkg.sv
// Shared types for the MCI CIF single-outstanding initiator.
// Command register layout, FSM states and default timeout.
package mci_pkg;

    localparam int MCI_CIF_AW = 32;
    localparam int MCI_CIF_DW = 32;
    localparam int MCI_CIF_UW = 32;
    localparam int MCI_CIF_INIT_TIMEOUT = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } mci_cif_init_state_e;

    typedef struct packed {
        logic [MCI_CIF_AW-1:0] addr;
        logic                  write;
        logic [MCI_CIF_DW-1:0] wdata;
        logic [MCI_CIF_UW-1:0] user;
    } mci_cif_init_cmd_t;

endpackage

// File: rtl/cif_if.sv
// MCI internal CIF request/response bundle.
// The requester drives dv/req_data; the target answers with hold/rdata/error.
interface cif_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 32
) ();

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [DATA_WIDTH-1:0] wdata;
        logic [USER_WIDTH-1:0] user;
        logic [7:0]            id;
    } req_data_t;

    logic                  dv;
    req_data_t             req_data;
    logic                  req_hold;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  error;

    modport request (
        output dv,
        output req_data,
        input  req_hold,
        input  rdata,
        input  error
    );

    modport response (
        input  dv,
        input  req_data,
        output req_hold,
        output rdata,
        output error
    );

endinterface

// File: rtl/mci_cif_init_timer.sv
// Saturating hold counter for the CIF initiator.
// expired marks the last allowed hold cycle; TIMEOUT_CYCLES = 0 disables it.
module mci_cif_init_timer
    import mci_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MCI_CIF_INIT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST =
        (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

endmodule

// File: rtl/mci_cif_initiator.sv
// Single-outstanding CIF initiator: valid/ready command in, dv/req_hold
// transaction on the CIF request port, registered valid/ready response out.
module mci_cif_initiator
    import mci_pkg::*;
#(
    parameter int ADDR_WIDTH     = MCI_CIF_AW,
    parameter int DATA_WIDTH     = MCI_CIF_DW,
    parameter int USER_WIDTH     = MCI_CIF_UW,
    parameter int TIMEOUT_CYCLES = MCI_CIF_INIT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_b,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [USER_WIDTH-1:0] cmd_user,

    cif_if.request                cif_req_if,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic                  busy
);

    // The command register layout is fixed by the shared package.
    if (ADDR_WIDTH != MCI_CIF_AW || DATA_WIDTH != MCI_CIF_DW ||
        USER_WIDTH != MCI_CIF_UW) begin : g_width_check
        $error("mci_cif_initiator widths must match mci_pkg");
    end

    mci_cif_init_state_e state_q, state_d;
    mci_cif_init_cmd_t   cmd_q;

    logic cmd_load;
    logic done;
    logic tout;
    logic tmr_clr;
    logic tmr_en;
    logic tmr_expired;

    mci_cif_init_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_b  (rst_b),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expired(tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_load = 1'b0;
        done     = 1'b0;
        tout     = 1'b0;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_load = 1'b1;
                    tmr_clr  = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                tmr_en = cif_req_if.req_hold;
                // A release on the final count wins over the timeout.
                if (!cif_req_if.req_hold) begin
                    done    = 1'b1;
                    state_d = RSP;
                end else if (tmr_expired) begin
                    tout    = 1'b1;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cmd_q       <= '0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (cmd_load) begin
                cmd_q.addr  <= cmd_addr;
                cmd_q.write <= cmd_write;
                cmd_q.wdata <= cmd_wdata;
                cmd_q.user  <= cmd_user;
            end
            if (done) begin
                rsp_rdata   <= (cmd_q.write || cif_req_if.error) ?
                               '0 : cif_req_if.rdata;
                rsp_error   <= cif_req_if.error;
                rsp_timeout <= 1'b0;
            end else if (tout) begin
                rsp_rdata   <= '0;
                rsp_error   <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign rsp_valid     = (state_q == RSP);
    assign busy          = (state_q != IDLE);
    assign cif_req_if.dv = (state_q == REQ);

    always_comb begin
        cif_req_if.req_data = '0;
        if (state_q == REQ) begin
            cif_req_if.req_data.addr  = cmd_q.addr;
            cif_req_if.req_data.write = cmd_q.write;
            cif_req_if.req_data.wdata = cmd_q.wdata;
            cif_req_if.req_data.user  = cmd_q.user;
        end
    end

    a_req_stable: assert property (
        @(posedge clk) disable iff (!rst_b)
        cif_req_if.dv |=> (!cif_req_if.dv || $stable(cif_req_if.req_data))
    );

    a_rsp_cmd_excl: assert property (
        @(posedge clk) disable iff (!rst_b)
        !(rsp_valid && cmd_ready)
    );

    a_dv_in_req: assert property (
        @(posedge clk) disable iff (!rst_b)
        cif_req_if.dv |-> (state_q == REQ)
    );

endmodule

// File: tb/tb_mci_cif_initiator.sv
// Directed bench for mci_cif_initiator: vector table plus backpressure
// and mid-request reset sequences, with the bench acting as CIF target.
module tb_mci_cif_initiator;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_wdata = '0;
    logic [31:0] cmd_user = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;
    logic        busy;

    always #5 clk = ~clk;

    cif_if #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .USER_WIDTH(32)
    ) cif ();

    mci_cif_initiator #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .USER_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_write  (cmd_write),
        .cmd_wdata  (cmd_wdata),
        .cmd_user   (cmd_user),
        .cif_req_if (cif),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .rsp_timeout(rsp_timeout),
        .busy       (busy)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] user;
        int          hold;
        logic [31:0] trdata;
        logic        terr;
        int          exp_dv;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    vec_t vecs[7];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic wr, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] user,
                                int hold, logic [31:0] trdata, logic terr,
                                int exp_dv, logic [31:0] exp_rdata,
                                logic exp_err, logic exp_to);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.user = user;
        v.hold = hold; v.trdata = trdata; v.terr = terr;
        v.exp_dv = exp_dv; v.exp_rdata = exp_rdata;
        v.exp_err = exp_err; v.exp_to = exp_to;
        return v;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dv"}, cif.dv, 1'b0);
        chk({tag, "_req_addr"}, cif.req_data.addr, '0);
        chk({tag, "_req_wdata"}, cif.req_data.wdata, '0);
        chk({tag, "_req_user"}, cif.req_data.user, '0);
        chk({tag, "_req_write"}, cif.req_data.write, 1'b0);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, '0);
        chk({tag, "_rsp_error"}, rsp_error, 1'b0);
        chk({tag, "_rsp_timeout"}, rsp_timeout, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    endtask

    task automatic issue(input vec_t v);
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_user  = v.user;
        @(negedge clk);
        // Scramble the inputs to show the request uses the registered copy.
        cmd_valid = 1'b0;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;
        cmd_user  = ~v.user;
        cmd_write = ~v.wr;
    endtask

    task automatic serve(input vec_t v, output int ndv);
        ndv = 0;
        for (int c = 0; c < 40 && cif.dv === 1'b1; c++) begin
            chk("req_addr", cif.req_data.addr, v.addr);
            chk("req_write", cif.req_data.write, v.wr);
            chk("req_wdata", cif.req_data.wdata, v.wdata);
            chk("req_user", cif.req_data.user, v.user);
            chk("req_id", cif.req_data.id, '0);
            chk("cmd_ready_req", cmd_ready, 1'b0);
            cif.req_hold = (ndv < v.hold);
            cif.rdata    = v.trdata;
            cif.error    = v.terr;
            ndv++;
            @(negedge clk);
        end
        cif.req_hold = 1'b0;
        cif.rdata    = '0;
        cif.error    = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int ndv;
        issue(v);
        serve(v, ndv);
        chk("dv_cycles", ndv, v.exp_dv);
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_error", rsp_error, v.exp_err);
        chk("rsp_timeout", rsp_timeout, v.exp_to);
        chk("busy_rsp", busy, 1'b1);
        chk("cmd_ready_rsp", cmd_ready, 1'b0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_done", rsp_valid, 1'b0);
        chk("cmd_ready_done", cmd_ready, 1'b1);
        chk("busy_done", busy, 1'b0);
    endtask

    initial begin
        vec_t bp;
        int   ndv;

        cif.req_hold = 1'b0;
        cif.rdata    = '0;
        cif.error    = 1'b0;

        vecs[0] = mk(1'b1, 32'h0040_0010, 32'hDEAD_BEEF, 32'h1, 0,
                     32'hFFFF_FFFF, 1'b0, 1, 32'h0, 1'b0, 1'b0);
        vecs[1] = mk(1'b0, 32'h0001_0004, 32'h0, 32'h0, 3,
                     32'h1234_5678, 1'b0, 4, 32'h1234_5678, 1'b0, 1'b0);
        vecs[2] = mk(1'b0, 32'h0000_0020, 32'h0, 32'h2, 1,
                     32'hAAAA_5555, 1'b1, 2, 32'h0, 1'b1, 1'b0);
        vecs[3] = mk(1'b0, 32'h0000_0024, 32'h0, 32'h3, 100,
                     32'h1111_1111, 1'b0, 8, 32'h0, 1'b1, 1'b1);
        vecs[4] = mk(1'b0, 32'h0000_0030, 32'h0, 32'h4, 0,
                     32'hCAFE_F00D, 1'b0, 1, 32'hCAFE_F00D, 1'b0, 1'b0);
        vecs[5] = mk(1'b0, 32'h0000_0034, 32'h0, 32'hA5, 7,
                     32'h0BAD_CAFE, 1'b0, 8, 32'h0BAD_CAFE, 1'b0, 1'b0);
        vecs[6] = mk(1'b1, 32'h0040_0014, 32'h0102_0304, 32'h6, 2,
                     32'h7777_7777, 1'b1, 3, 32'h0, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_b = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Response backpressure with cmd_valid toggling.
        bp = mk(1'b0, 32'h0000_0040, 32'h0, 32'h9, 0,
                32'h55AA_33CC, 1'b0, 1, 32'h55AA_33CC, 1'b0, 1'b0);
        issue(bp);
        serve(bp, ndv);
        chk("bp_dv_cycles", ndv, 1);
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h55AA_33CC);
            chk("bp_rsp_error", rsp_error, 1'b0);
            chk("bp_cmd_ready", cmd_ready, 1'b0);
            chk("bp_no_dv", cif.dv, 1'b0);
            cmd_valid = ~cmd_valid;
            cmd_addr  = 32'h0000_0F00 + 32'(c);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("bp_rsp_valid_end", rsp_valid, 1'b1);
        chk("bp_rsp_rdata_end", rsp_rdata, 32'h55AA_33CC);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_rsp_valid_done", rsp_valid, 1'b0);
        chk("bp_no_dv_after", cif.dv, 1'b0);
        chk("bp_cmd_ready_done", cmd_ready, 1'b1);

        // Reset pulsed during the second cycle of a held request.
        bp = mk(1'b0, 32'h0000_0050, 32'h0, 32'h5, 100,
                32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        issue(bp);
        chk("rr_dv_c1", cif.dv, 1'b1);
        cif.req_hold = 1'b1;
        @(negedge clk);
        chk("rr_dv_c2", cif.dv, 1'b1);
        rst_b = 1'b0;
        #1;
        chk_reset_vals("rr_async");
        @(negedge clk);
        rst_b = 1'b1;
        cif.req_hold = 1'b0;
        @(negedge clk);
        chk_reset_vals("rr_release");

        run_vec(vecs[4]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mci_cif_initiator.md
# mci_cif_initiator

Single-outstanding initiator for the MCI internal CIF request/response interface: it accepts one command at a time on a valid/ready port, drives it onto a `cif_if.request` port until the target completes it, and returns read data, error and timeout status on a valid/ready response port. It sits upstream of an MCI CIF decoder or target, for example mailbox, trace buffer or register block. Internal masters such as MCU-side DMA helpers and test sequencers use it to reach CIF targets without hand-coding the `dv`/`req_hold` handshake.

## Interface
- `ADDR_WIDTH`, 32: width of `cmd_addr` and of `req_data.addr`.
- `DATA_WIDTH`, 32: width of write and read data.
- `USER_WIDTH`, 32: width of `cmd_user` and of `req_data.user`.
- `TIMEOUT_CYCLES`, 256: number of hold cycles before the initiator abandons a request; 0 disables the timeout.
- `clk`  in  1  block clock.
- `rst_b`  in  1  reset; asynchronous assertion, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_addr`  in  ADDR_WIDTH  byte address.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_wdata`  in  DATA_WIDTH  write data.
- `cmd_user`  in  USER_WIDTH  AXI user value presented to the target.
- `cif_req_if`  cif_if.request  —  drives `dv` and `req_data`; samples `req_hold`, `rdata` and `error`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed when both `rsp_valid` and `rsp_ready` are high.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes, errors and timeouts.
- `rsp_error`  out  1  target error or timeout.
- `rsp_timeout`  out  1  request was abandoned by the timeout.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states and transitions:
  - IDLE:
    - `cmd_ready` = 1.
    - On a command handshake, register addr/write/wdata/user, clear the hold counter, go to REQ.
  - REQ:
    - `dv` = 1; `req_data` is driven from the registered command.
    - Unused `req_data` fields are 0.
    - The cycle with `dv & ~req_hold` completes the transaction:
      - capture `rdata` (forced to 0 when write or `error`) and `error`;
      - go to RSP.
    - A cycle with `dv & req_hold` increments the hold counter.
    - Timeout: when `TIMEOUT_CYCLES != 0`, the counter equals `TIMEOUT_CYCLES-1`, and `req_hold` is still high:
      - set `rsp_timeout` = 1 and `rsp_error` = 1, `rsp_rdata` = 0;
      - go to RSP.
  - RSP:
    - `rsp_valid` = 1 with stable `rsp_*`.
    - On `rsp_ready`, go to IDLE.
- The command registers are stable for the whole of REQ, so `req_data` does not change while `dv` is high.
- `cmd_*` inputs are ignored outside IDLE.
- Hold counter width is `$clog2(TIMEOUT_CYCLES+1)`. It saturates and never wraps.
- A single outstanding transaction only; there is no pipelining.

## Timing
- Reset values:
  - state = IDLE, `cmd_ready` = 1.
  - `dv` = 0, `req_data` = 0.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_error` = 0, `rsp_timeout` = 0, `busy` = 0.
- Command accepted at edge N → `dv` high in cycle N+1.
- Zero-wait target: `dv` is high for exactly 1 cycle. `rsp_valid` rises in cycle N+2.
- Minimum period per transaction is 3 cycles (IDLE, REQ, RSP). `cmd_ready` is low from the accept edge until the RSP handshake edge.
- For a target holding H cycles, `dv` is high for H+1 cycles.
- On timeout, `dv` is high for exactly `TIMEOUT_CYCLES` cycles and then deasserts. Targets must tolerate withdrawal of `dv`, which is the documented recovery path.
- `rsp_*` are registered outputs and do not change while `rsp_valid` && !`rsp_ready`.
- Reset asserted mid-REQ or mid-RSP: `dv` and `rsp_valid` drop asynchronously and the pending transaction is discarded.
- Completion and timeout in the same cycle (`req_hold` = 0 on the final count) is a normal completion; no timeout is flagged.

## Structure
- `mci_pkg` holds:
  - `mci_cif_init_state_e` (IDLE, REQ, RSP);
  - the `mci_cif_init_cmd_t` struct (addr, write, wdata, user);
  - the default `MCI_CIF_INIT_TIMEOUT` = 256.
- Sub-module `mci_cif_init_timer`: a saturating hold counter with clear, enable and `expired` outputs, parameterized by `TIMEOUT_CYCLES`.
- Assertions:
  - `req_data` is stable while `dv` is high;
  - `rsp_valid` and `cmd_ready` are never high together;
  - `dv` implies state REQ.

## Test plan
- **Zero-wait write:** write addr 0x0040_0010, wdata 0xDEAD_BEEF, user 0x1, `req_hold` = 0 → `dv` high for 1 cycle with those fields; `rsp_error` = 0, `rsp_rdata` = 0.
- **Read with hold:** read addr 0x0001_0004, target holds 3 cycles then returns 0x1234_5678 → `dv` high for 4 cycles; `rsp_rdata` = 0x1234_5678.
- **Target error:** a read completes with `error` = 1 → `rsp_error` = 1, `rsp_timeout` = 0, `rsp_rdata` = 0.
- **Timeout:** `TIMEOUT_CYCLES` = 8 with `req_hold` stuck at 1 → `dv` high exactly 8 cycles; `rsp_error` = 1, `rsp_timeout` = 1. A later command completes normally.
- **Response backpressure:** `rsp_ready` held low for 5 cycles while `cmd_valid` toggles → `rsp_*` stable, `cmd_ready` = 0, no extra `dv`.
- **Reset mid-REQ:** `rst_b` pulsed low during cycle 2 of a held request → `dv` = 0 immediately, all outputs at reset values, IDLE after release.
